// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue and its entry storage.
package branch_resolve_queue_pkg;

   localparam int unsigned DELAY_SLOT_OFFSET_DEFAULT = 32'd8;
   localparam logic [31:0] NO_UPDATE_ADDR            = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] addr;
      logic        taken;
      logic [31:0] target;
   } branch_entry_t;

   typedef enum logic [1:0] {
      Q_EMPTY   = 2'd0,
      Q_PARTIAL = 2'd1,
      Q_FULL    = 2'd2
   } queue_state_t;

   // Sequential fetch address past the branch and its delay slot, wrapping at 32 bits.
   function automatic logic [31:0] fallthrough_addr(input logic [31:0] addr,
                                                    input logic [31:0] offset);
      return addr + offset;
   endfunction

endpackage

// File: rtl/branch_entry_fifo.sv
// In-flight branch storage: circular FIFO with push, pop and a flush that empties it
// by snapping the head pointer onto the tail.
module branch_entry_fifo
   import branch_resolve_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     push,
   input  branch_entry_t            push_entry,
   input  logic                     pop,
   input  logic                     flush,
   output branch_entry_t            head_entry,
   output logic [$clog2(DEPTH):0]   count,
   output queue_state_t             state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   branch_entry_t mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;

   // Entry storage; contents are not reset, the pointers alone define validity.
   always_ff @(posedge CLK) begin
      if (push && !flush) begin
         mem_r[wr_ptr_r] <= push_entry;
      end
   end

   // Pointer and occupancy update; flush wins over push and pop.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         rd_ptr_r <= wr_ptr_r;
         count_r  <= {CW{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Occupancy classification used for ready and empty decisions.
   always_comb begin
      state = Q_PARTIAL;
      if (count_r == {CW{1'b0}}) begin
         state = Q_EMPTY;
      end else if (count_r == FULL_COUNT) begin
         state = Q_FULL;
      end else begin
         state = Q_PARTIAL;
      end
   end

   assign head_entry = mem_r[rd_ptr_r];
   assign count      = count_r;

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks predicted branches in fetch order and compares each against its execute-stage
// outcome, producing predictor updates and mispredict redirects one cycle after the pop.
module branch_resolve_queue
   import branch_resolve_queue_pkg::*;
#(
   parameter int          DEPTH             = 8,
   parameter int unsigned DELAY_SLOT_OFFSET = DELAY_SLOT_OFFSET_DEFAULT
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     Pred_valid,
   input  logic [31:0]              Pred_addr,
   input  logic                     Pred_taken,
   input  logic [31:0]              Pred_target,
   output logic                     Pred_ready,
   input  logic                     Exec_valid,
   input  logic                     Exec_taken,
   input  logic [31:0]              Exec_target,
   output logic                     Branch_resolved,
   output logic [31:0]              Branch_addr_OUT,
   output logic                     Mispredict,
   output logic [31:0]              Redirect_addr,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Underflow
);

   branch_entry_t push_entry_s;
   branch_entry_t head_s;
   queue_state_t  state_s;
   logic          push_s;
   logic          pop_s;
   logic          flush_s;
   logic          mispredict_s;
   logic [31:0]   redirect_s;

   logic          resolved_r;
   logic [31:0]   branch_addr_r;
   logic          mispredict_r;
   logic [31:0]   redirect_r;
   logic          underflow_r;

   // Ready looks only at the registered occupancy, so a same-cycle pop never frees a slot.
   assign Pred_ready = (state_s != Q_FULL);
   assign push_s     = Pred_valid && (state_s != Q_FULL);
   assign pop_s      = Exec_valid && (state_s != Q_EMPTY);
   assign flush_s    = pop_s && mispredict_s;

   // Pack the fetch-stage prediction into a queue entry.
   always_comb begin
      push_entry_s        = '0;
      push_entry_s.addr   = Pred_addr;
      push_entry_s.taken  = Pred_taken;
      push_entry_s.target = Pred_target;
   end

   // Compare the head prediction with the actual outcome and pick the correct fetch address.
   always_comb begin
      mispredict_s = 1'b0;
      redirect_s   = NO_UPDATE_ADDR;
      if (Exec_taken != head_s.taken) begin
         mispredict_s = 1'b1;
      end else if (Exec_taken && (Exec_target != head_s.target)) begin
         mispredict_s = 1'b1;
      end else begin
         mispredict_s = 1'b0;
      end
      if (Exec_taken) begin
         redirect_s = Exec_target;
      end else begin
         redirect_s = fallthrough_addr(head_s.addr, 32'(DELAY_SLOT_OFFSET));
      end
   end

   branch_entry_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK        (CLK),
      .RESET      (RESET),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .flush      (flush_s),
      .head_entry (head_s),
      .count      (Count),
      .state      (state_s)
   );

   // Registered resolution outputs; an address of zero tells the predictor there is no update.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         resolved_r    <= 1'b0;
         branch_addr_r <= NO_UPDATE_ADDR;
         mispredict_r  <= 1'b0;
         redirect_r    <= NO_UPDATE_ADDR;
         underflow_r   <= 1'b0;
      end else begin
         if (pop_s) begin
            resolved_r    <= Exec_taken;
            branch_addr_r <= head_s.addr;
            mispredict_r  <= mispredict_s;
            redirect_r    <= mispredict_s ? redirect_s : NO_UPDATE_ADDR;
         end else begin
            resolved_r    <= 1'b0;
            branch_addr_r <= NO_UPDATE_ADDR;
            mispredict_r  <= 1'b0;
            redirect_r    <= NO_UPDATE_ADDR;
         end
         if (Exec_valid && (state_s == Q_EMPTY)) begin
            underflow_r <= 1'b1;
         end else begin
            underflow_r <= underflow_r;
         end
      end
   end

   assign Branch_resolved = resolved_r;
   assign Branch_addr_OUT = branch_addr_r;
   assign Mispredict      = mispredict_r;
   assign Redirect_addr   = redirect_r;
   assign Underflow       = underflow_r;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH 8, delay-slot offset 8).
module tb_branch_resolve_queue;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        Pred_valid = 1'b0;
   logic [31:0] Pred_addr = 32'h0;
   logic        Pred_taken = 1'b0;
   logic [31:0] Pred_target = 32'h0;
   logic        Pred_ready;
   logic        Exec_valid = 1'b0;
   logic        Exec_taken = 1'b0;
   logic [31:0] Exec_target = 32'h0;
   logic        Branch_resolved;
   logic [31:0] Branch_addr_OUT;
   logic        Mispredict;
   logic [31:0] Redirect_addr;
   logic [3:0]  Count;
   logic        Underflow;

   int checks = 0;
   int failures = 0;

   branch_resolve_queue #(.DEPTH(8), .DELAY_SLOT_OFFSET(8)) dut (
      .CLK(CLK), .RESET(RESET),
      .Pred_valid(Pred_valid), .Pred_addr(Pred_addr), .Pred_taken(Pred_taken),
      .Pred_target(Pred_target), .Pred_ready(Pred_ready),
      .Exec_valid(Exec_valid), .Exec_taken(Exec_taken), .Exec_target(Exec_target),
      .Branch_resolved(Branch_resolved), .Branch_addr_OUT(Branch_addr_OUT),
      .Mispredict(Mispredict), .Redirect_addr(Redirect_addr),
      .Count(Count), .Underflow(Underflow)
   );

   always #5 CLK = ~CLK;

   task automatic cycle();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic push(input logic [31:0] a, input logic t, input logic [31:0] tg);
      Pred_valid = 1'b1; Pred_addr = a; Pred_taken = t; Pred_target = tg;
      cycle();
      Pred_valid = 1'b0;
   endtask

   task automatic resolve(input logic t, input logic [31:0] tg);
      Exec_valid = 1'b1; Exec_taken = t; Exec_target = tg;
      cycle();
      Exec_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (Count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
      checks++; if (Pred_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", Pred_ready); end
      checks++; if ({Branch_resolved, Mispredict, Underflow} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {Branch_resolved, Mispredict, Underflow}); end
      checks++; if ({Branch_addr_OUT, Redirect_addr} !== 64'h0) begin failures++; $display("FAIL reset_addrs got=%h exp=0", {Branch_addr_OUT, Redirect_addr}); end
      @(negedge CLK);
      RESET = 1'b1;
      cycle();
      checks++; if (Count !== 4'd0) begin failures++; $display("FAIL post_reset_count got=%0d exp=0", Count); end
   endtask

   task automatic test_taken_correct();
      push(32'h400, 1'b1, 32'h480);
      checks++; if (Count !== 4'd1) begin failures++; $display("FAIL push_count got=%0d exp=1", Count); end
      resolve(1'b1, 32'h480);
      checks++; if (Branch_addr_OUT !== 32'h400) begin failures++; $display("FAIL taken_addr got=%h exp=400", Branch_addr_OUT); end
      checks++; if (Branch_resolved !== 1'b1) begin failures++; $display("FAIL taken_resolved got=%b exp=1", Branch_resolved); end
      checks++; if (Mispredict !== 1'b0 || Redirect_addr !== 32'h0) begin failures++; $display("FAIL taken_mispredict got=%b/%h exp=0/0", Mispredict, Redirect_addr); end
      checks++; if (Count !== 4'd0) begin failures++; $display("FAIL taken_count got=%0d exp=0", Count); end
      cycle();
      checks++; if (Branch_addr_OUT !== 32'h0 || Branch_resolved !== 1'b0) begin failures++; $display("FAIL update_one_cycle got=%h/%b exp=0/0", Branch_addr_OUT, Branch_resolved); end
   endtask

   task automatic test_mispredict();
      push(32'h500, 1'b0, 32'h0);
      resolve(1'b1, 32'h600);
      checks++; if (Mispredict !== 1'b1) begin failures++; $display("FAIL dir_mispredict got=%b exp=1", Mispredict); end
      checks++; if (Redirect_addr !== 32'h600) begin failures++; $display("FAIL dir_redirect got=%h exp=600", Redirect_addr); end
      checks++; if (Branch_addr_OUT !== 32'h500 || Branch_resolved !== 1'b1) begin failures++; $display("FAIL dir_update got=%h/%b exp=500/1", Branch_addr_OUT, Branch_resolved); end
      push(32'h504, 1'b0, 32'h0);
      resolve(1'b0, 32'h0);
      checks++; if (Mispredict !== 1'b0 || Redirect_addr !== 32'h0) begin failures++; $display("FAIL nt_correct got=%b/%h exp=0/0", Mispredict, Redirect_addr); end
      checks++; if (Branch_addr_OUT !== 32'h504 || Branch_resolved !== 1'b0) begin failures++; $display("FAIL nt_update got=%h/%b exp=504/0", Branch_addr_OUT, Branch_resolved); end
      push(32'h540, 1'b1, 32'h580);
      resolve(1'b1, 32'h5A0);
      checks++; if (Mispredict !== 1'b1 || Redirect_addr !== 32'h5A0) begin failures++; $display("FAIL target_mispredict got=%b/%h exp=1/5a0", Mispredict, Redirect_addr); end
      push(32'hFFFF_FFFC, 1'b1, 32'h100);
      resolve(1'b0, 32'h0);
      checks++; if (Mispredict !== 1'b1 || Redirect_addr !== 32'h4) begin failures++; $display("FAIL redirect_wrap got=%b/%h exp=1/4", Mispredict, Redirect_addr); end
   endtask

   task automatic test_flush();
      push(32'h700, 1'b1, 32'h780);
      push(32'h710, 1'b0, 32'h0);
      push(32'h720, 1'b0, 32'h0);
      checks++; if (Count !== 4'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", Count); end
      Pred_valid = 1'b1; Pred_addr = 32'h730; Pred_taken = 1'b0; Pred_target = 32'h0;
      resolve(1'b0, 32'h0);
      Pred_valid = 1'b0;
      checks++; if (Mispredict !== 1'b1 || Redirect_addr !== 32'h708) begin failures++; $display("FAIL flush_redirect got=%b/%h exp=1/708", Mispredict, Redirect_addr); end
      checks++; if (Count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", Count); end
      cycle();
      checks++; if (Mispredict !== 1'b0) begin failures++; $display("FAIL flush_pulse got=%b exp=0", Mispredict); end
      push(32'h740, 1'b1, 32'h7C0);
      resolve(1'b1, 32'h7C0);
      checks++; if (Branch_addr_OUT !== 32'h740 || Mispredict !== 1'b0) begin failures++; $display("FAIL after_flush got=%h/%b exp=740/0", Branch_addr_OUT, Mispredict); end
   endtask

   task automatic test_full_wrap();
      logic [31:0] exp_addr;
      for (int i = 0; i < 8; i++) push(32'h1000 + 32'(i) * 32'd4, 1'b0, 32'h0);
      checks++; if (Pred_ready !== 1'b0 || Count !== 4'd8) begin failures++; $display("FAIL full got=%b/%0d exp=0/8", Pred_ready, Count); end
      Pred_valid = 1'b1; Pred_addr = 32'h2000; Pred_taken = 1'b0; Pred_target = 32'h0;
      resolve(1'b0, 32'h0);
      Pred_valid = 1'b0;
      checks++; if (Count !== 4'd7 || Branch_addr_OUT !== 32'h1000) begin failures++; $display("FAIL full_push_pop got=%0d/%h exp=7/1000", Count, Branch_addr_OUT); end
      for (int k = 0; k < 12; k++) begin
         exp_addr = (k < 7) ? 32'h1004 + 32'(k) * 32'd4 : 32'h3000 + 32'(k - 7) * 32'd4;
         Pred_valid = 1'b1; Pred_addr = 32'h3000 + 32'(k) * 32'd4; Pred_taken = 1'b0;
         resolve(1'b0, 32'h0);
         Pred_valid = 1'b0;
         checks++; if (Branch_addr_OUT !== exp_addr || Count !== 4'd7) begin failures++; $display("FAIL wrap_pair%0d got=%h/%0d exp=%h/7", k, Branch_addr_OUT, Count, exp_addr); end
      end
      for (int k = 0; k < 7; k++) begin
         exp_addr = 32'h3014 + 32'(k) * 32'd4;
         resolve(1'b0, 32'h0);
         checks++; if (Branch_addr_OUT !== exp_addr || Count !== 4'(6 - k)) begin failures++; $display("FAIL drain%0d got=%h/%0d exp=%h/%0d", k, Branch_addr_OUT, Count, exp_addr, 6 - k); end
      end
   endtask

   task automatic test_underflow();
      resolve(1'b1, 32'h123);
      checks++; if (Underflow !== 1'b1) begin failures++; $display("FAIL underflow_set got=%b exp=1", Underflow); end
      checks++; if (Branch_addr_OUT !== 32'h0 || Mispredict !== 1'b0 || Branch_resolved !== 1'b0) begin failures++; $display("FAIL underflow_noupd got=%h/%b/%b exp=0/0/0", Branch_addr_OUT, Mispredict, Branch_resolved); end
      cycle();
      checks++; if (Underflow !== 1'b1) begin failures++; $display("FAIL underflow_sticky got=%b exp=1", Underflow); end
   endtask

   task automatic test_reset_midop();
      push(32'h800, 1'b0, 32'h0);
      push(32'h810, 1'b0, 32'h0);
      push(32'h820, 1'b0, 32'h0);
      checks++; if (Count !== 4'd3) begin failures++; $display("FAIL midop_pre got=%0d exp=3", Count); end
      RESET = 1'b0;
      #1;
      checks++; if (Count !== 4'd0 || Underflow !== 1'b0 || Pred_ready !== 1'b1) begin failures++; $display("FAIL midop_reset got=%0d/%b/%b exp=0/0/1", Count, Underflow, Pred_ready); end
      @(negedge CLK);
      RESET = 1'b1;
      cycle();
      push(32'h900, 1'b1, 32'h980);
      resolve(1'b1, 32'h980);
      checks++; if (Branch_addr_OUT !== 32'h900 || Mispredict !== 1'b0) begin failures++; $display("FAIL midop_discard got=%h/%b exp=900/0", Branch_addr_OUT, Mispredict); end
   endtask

   initial begin
      test_reset();
      test_taken_correct();
      test_mispredict();
      test_flush();
      test_full_wrap();
      test_underflow();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning in-flight branch entries (power of two, 2..64).
REQ-002 SHALL have parameter DELAY_SLOT_OFFSET, default 8, meaning fall-through redirect offset from branch address (MIPS delay slot).
REQ-003 SHALL have one clock and an asynchronous active-low reset: CLK in 1, all state on rising edge; RESET in 1, asynchronous, active-low.
REQ-004 Pred_valid  in  1  fetch stage presents a predicted branch.
REQ-005 Pred_addr  in  32  branch instruction address.
REQ-006 Pred_taken  in  1  predictor's Taken for that branch.
REQ-007 Pred_target  in  32  predicted taken target.
REQ-008 Pred_ready  out  1  queue can accept; high iff count < DEPTH.
REQ-009 Exec_valid  in  1  execute stage resolves the oldest queued branch.
REQ-010 Exec_taken  in  1  actual branch outcome.
REQ-011 Exec_target  in  32  actual taken target.
REQ-012 Branch_resolved  out  1  actual outcome returned to predictor.
REQ-013 Branch_addr_OUT  out  32  resolved branch address; 0 means "no update this cycle".
REQ-014 Mispredict  out  1  one-cycle flush pulse.
REQ-015 Redirect_addr  out  32  correct next fetch address, valid with Mispredict.
REQ-016 Count  out  $clog2(DEPTH)+1  current occupancy.
REQ-017 Underflow  out  1  sticky error: Exec_valid while empty.

Function
REQ-018 SHALL push {addr, taken, target} at tail when Pred_valid && Pred_ready; Pred_ready ignores same-cycle pop (no push when full).
REQ-019 SHALL pop head when Exec_valid && Count != 0; outputs REQ-012..015 registered, valid the cycle after pop (latency 1).
REQ-020 Branch_addr_OUT SHALL equal popped address for exactly one cycle per pop, else 0; Branch_resolved = Exec_taken that cycle, else 0.
REQ-021 Mispredict SHALL assert iff Exec_taken != stored taken, or both taken and Exec_target != stored target.
REQ-022 Redirect_addr SHALL be Exec_target if Exec_taken, else popped address + DELAY_SLOT_OFFSET (32-bit wrap); 0 when Mispredict low.
REQ-023 On mispredict pop SHALL flush all remaining entries (Count -> 0, head = tail) in the pop cycle; a same-cycle push SHALL be dropped.
REQ-024 Simultaneous non-mispredict push and pop SHALL leave Count unchanged; pointers wrap modulo DEPTH.
REQ-025 Exec_valid with Count == 0 SHALL not pop, SHALL drive no update, SHALL set Underflow until reset.
REQ-026 Queue state: EMPTY (Count 0), PARTIAL, FULL (Count DEPTH); transitions only via REQ-018/019/023.

Reset
REQ-027 RESET low SHALL immediately clear pointers, Count, Underflow, Branch_resolved, Branch_addr_OUT, Mispredict, Redirect_addr to 0; Pred_ready to 1.
REQ-028 Reset mid-operation SHALL discard all entries; entry storage need not be cleared.
REQ-029 Deassertion SHALL take effect on the next rising CLK; no pop/push occurs in the reset cycle.

Structure
REQ-030 Shared package SHALL hold DELAY_SLOT_OFFSET default, entry struct {addr, taken, target}, and the "address 0 = no update" constant.
REQ-031 Storage SHALL be a sub-module branch_entry_fifo (DEPTH-parameterised, push/pop/flush, count); compare/redirect logic stays in top.

Verification
REQ-032 Push addr 0x400 taken target 0x480, resolve taken 0x480 -> next cycle Branch_addr_OUT=0x400, Branch_resolved=1, Mispredict=0.
REQ-033 Push 0x500 not-taken, resolve taken target 0x600 -> Mispredict=1, Redirect_addr=0x600; push 0x504 not-taken, resolve not-taken -> Mispredict=0.
REQ-034 Push 0x700 taken target 0x780, then 0x710, 0x720; resolve 0x700 not-taken -> Mispredict=1, Redirect_addr=0x708, Count=0 next cycle.
REQ-035 Fill 8 entries -> Pred_ready=0; push+pop same cycle when full -> push rejected, Count=7; 12 further push/pop pairs -> FIFO order across wrap.
REQ-036 Exec_valid at Count=0 -> Underflow=1, Branch_addr_OUT=0; RESET low with 3 entries -> Count=0, Underflow=0, Pred_ready=1 immediately.
